dma_mem_responder: RTL
======================

Name: dma_mem_responder

Overview:
- Memory-side responder for the engine/arbiter DMA request protocol (req/rw/addr/len/ack).
- Accepts one burst request at a time, then streams 64-bit words into or out of a local word-addressed SRAM model with valid/ready handshakes.
- Closes each burst with a one-cycle ack.
- Sits below the memory arbiter and stands in for host memory in core-level simulation.

Parameters:
ADDR_W, 48, request address width (byte address)
DATA_W, 64, word width
LEN_W, 32, burst length width (in words)
DEPTH_LOG, 13, log2 of memory depth in words (8192)

Ports:
clk  in  1  clock; all logic rising-edge
rst_n  in  1  asynchronous active-low reset
req  in  1  request, level; held by requester until ack
rw  in  1  1 = write (requester to memory), 0 = read
addr  in  ADDR_W  byte address; word index = addr[DEPTH_LOG+2:3], addr[2:0] ignored
len  in  LEN_W  burst length in words
wr_valid  in  1  write data valid
wr_data  in  DATA_W  write data word
wr_ready  out  1  responder accepts wr_data this cycle
rd_valid  out  1  read data valid
rd_data  out  DATA_W  read data word
rd_ready  in  1  requester accepts rd_data this cycle
ack  out  1  one-cycle pulse: burst complete
err  out  1  valid with ack: burst rejected, no memory access
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE; ack, err, busy, wr_ready, rd_valid all 0; rd_data 0; counters 0. Memory contents are not cleared.
- States: IDLE, WRITE, READ, ACK, HOLD.
- IDLE with req=1:
  - Latch rw, base = word index, remaining = len.
  - If len==0 or base+len > 2^DEPTH_LOG (computed in LEN_W+1 bits, no wrap): go to ACK with err=1.
  - Otherwise go to WRITE (rw=1) or READ (rw=0).
- WRITE:
  - wr_ready=1.
  - Each cycle with wr_valid & wr_ready: mem[base+i] <= wr_data; i++.
  - After the len-th word, go to ACK; wr_ready drops the next cycle.
- READ:
  - Synchronous SRAM with 1-cycle read latency, plus a one-entry skid register.
  - First rd_valid appears 2 cycles after the request is latched.
  - rd_data is held stable while rd_valid & !rd_ready.
  - Sustains 1 word/cycle when rd_ready is held high.
  - Words are delivered in ascending address order.
  - After the len-th handshake, go to ACK; no extra words are emitted.
- ACK: ack=1 for exactly one cycle (err=1 on reject), then go to HOLD.
- HOLD: one cycle, req ignored (requester drops req after seeing ack), then go to IDLE.
- A req still high in IDLE after HOLD is a new request.
- req dropped mid-burst is ignored; the burst runs to completion.
- Reset mid-burst aborts immediately; memory words already written persist.
- Burst ending exactly at the last word (base+len == 2^DEPTH_LOG) is legal.

Optional Feature:
- Macro: DMA_MEM_RESPONDER_STATS_EN.
- Defined: adds outputs stat_wr_words[31:0], stat_rd_words[31:0], stat_errs[15:0].
  - Each increments on a write handshake, read handshake, or err ack respectively.
  - Each saturates at all-ones and is reset by rst_n only.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Write burst addr=0x40, len=4, data 0xA..0xD, wr_valid continuous -> mem[8..11]=A..D; ack pulses once, err=0, the cycle after the 4th handshake.
- Read burst addr=0x40, len=4, rd_ready=1 -> rd_valid first high 2 cycles after latch; data A,B,C,D on consecutive cycles; then ack.
- Same read with rd_ready toggling 1,0,0,1,... -> rd_data stable while stalled; exactly 4 handshakes; order A..D.
- len=0, and addr=0xFFF8 with len=2 (word 8191 + 1 beyond) -> ack with err=1 after 1 cycle; no wr_ready/rd_valid; memory unchanged. addr=0xFFF8 with len=1 -> legal.
- Reset asserted after 2 of 4 write words -> all outputs 0 asynchronously; mem[8..9] updated, mem[10..11] unchanged; next request serviced normally.
- Back-to-back: req held high through ack -> HOLD ignores req for one cycle; second burst latched on the following cycle. With DMA_MEM_RESPONDER_STATS_EN, counters match handshake totals.

Source files
------------

// File: rtl/dma_mem_if.sv
// Requester/responder bus for the DMA memory protocol: burst request, write stream, read stream, ack.
// The master modport is the requester side; the slave modport is the memory responder side.
interface dma_mem_if #(
  parameter int unsigned ADDR_W = 48,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned LEN_W  = 32
) ();
  logic              req;
  logic              rw;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  len;
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_ready;
  logic              ack;
  logic              err;
  logic              busy;

  modport master (
    output req, rw, addr, len, wr_valid, wr_data, rd_ready,
    input  wr_ready, rd_valid, rd_data, ack, err, busy
  );

  modport slave (
    input  req, rw, addr, len, wr_valid, wr_data, rd_ready,
    output wr_ready, rd_valid, rd_data, ack, err, busy
  );
endinterface

// File: rtl/dma_mem_responder.sv
// Memory-side DMA responder: one burst at a time into/out of a word-addressed SRAM, closed by a one-cycle ack.
// Optional DMA_MEM_RESPONDER_STATS_EN adds saturating write/read/error counters.
module dma_mem_responder #(
  parameter int unsigned ADDR_W    = 48,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned LEN_W     = 32,
  parameter int unsigned DEPTH_LOG = 13
) (
  input  logic       clk,
  input  logic       rst_n,
  dma_mem_if.slave   bus
`ifdef DMA_MEM_RESPONDER_STATS_EN
  ,
  output logic [31:0] stat_wr_words,
  output logic [31:0] stat_rd_words,
  output logic [15:0] stat_errs
`endif
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG;
  localparam logic [LEN_W:0] MEM_WORDS = (LEN_W+1)'(1) << DEPTH_LOG;

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_ACK, S_HOLD} state_e;

  state_e                 state_q, state_d;
  logic [DEPTH_LOG-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]       rem_q, rem_d;
  logic [LEN_W-1:0]       iss_q, iss_d;
  logic                   ack_q, ack_d, err_q, err_d, busy_q, busy_d;
  logic                   wr_ready_q, wr_ready_d;
  logic                   rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]      rd_data_q, rd_data_d;
  logic [DATA_W-1:0]      skid_q, skid_d;
  logic                   skid_vld_q, skid_vld_d;
  logic                   s1_vld_q, s1_vld_d;
  logic [DATA_W-1:0]      mem_rdata_q;
  logic [DATA_W-1:0]      mem [DEPTH];

  logic [DEPTH_LOG-1:0]   base_c;
  logic [LEN_W:0]         end_c;
  logic                   reject_c, wr_hs_c, pop_c, wr_en_c, rd_issue_c, out_free_c;
  logic [1:0]             occ_c;
  logic                   unused_addr_bits;

  assign base_c   = bus.addr[DEPTH_LOG+2:3];
  assign end_c    = (LEN_W+1)'(base_c) + (LEN_W+1)'(bus.len);
  assign reject_c = (bus.len == '0) || (end_c > MEM_WORDS);
  assign wr_hs_c  = wr_ready_q & bus.wr_valid;
  assign pop_c    = rd_valid_q & bus.rd_ready;
  assign unused_addr_bits = ^{bus.addr[ADDR_W-1:DEPTH_LOG+3], bus.addr[2:0]};

  // Words sitting in SRAM output, output register and skid once this edge's pop is taken
  assign occ_c      = 2'(rd_valid_q) + 2'(skid_vld_q) + 2'(s1_vld_q) - 2'(pop_c);
  assign out_free_c = ~rd_valid_q | pop_c;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    iss_d      = iss_q;
    err_d      = 1'b0;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    s1_vld_d   = 1'b0;
    rd_issue_c = 1'b0;
    wr_en_c    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          addr_d = base_c;
          rem_d  = bus.len;
          iss_d  = bus.len;
          if (reject_c) begin
            state_d = S_ACK;
            err_d   = 1'b1;
          end else begin
            state_d = bus.rw ? S_WRITE : S_READ;
          end
        end
      end
      S_WRITE: begin
        if (wr_hs_c) begin
          wr_en_c = 1'b1;
          addr_d  = addr_q + DEPTH_LOG'(1);
          rem_d   = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) state_d = S_ACK;
        end
      end
      S_READ: begin
        // Issue only when the word can land in the output register or skid without a pop
        if ((iss_q != '0) && (occ_c <= 2'd1)) begin
          rd_issue_c = 1'b1;
          s1_vld_d   = 1'b1;
          iss_d      = iss_q - LEN_W'(1);
          addr_d     = addr_q + DEPTH_LOG'(1);
        end
        if (pop_c) begin
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) state_d = S_ACK;
        end
      end
      S_ACK:   state_d = S_HOLD;
      S_HOLD:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Read data path: skid drains first so words stay in address order
    if (out_free_c) begin
      if (skid_vld_q) begin
        rd_data_d  = skid_q;
        rd_valid_d = 1'b1;
        skid_d     = mem_rdata_q;
        skid_vld_d = s1_vld_q;
      end else if (s1_vld_q) begin
        rd_data_d  = mem_rdata_q;
        rd_valid_d = 1'b1;
      end else begin
        rd_valid_d = 1'b0;
      end
    end else if (s1_vld_q) begin
      skid_d     = mem_rdata_q;
      skid_vld_d = 1'b1;
    end

    busy_d     = (state_d != S_IDLE);
    ack_d      = (state_d == S_ACK);
    wr_ready_d = (state_d == S_WRITE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      iss_q      <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      wr_ready_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
      s1_vld_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      iss_q      <= iss_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      wr_ready_q <= wr_ready_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
      s1_vld_q   <= s1_vld_d;
    end
  end

  // SRAM array and its registered read port; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en_c)    mem[addr_q] <= bus.wr_data;
    if (rd_issue_c) mem_rdata_q <= mem[addr_q];
  end

  assign bus.ack      = ack_q;
  assign bus.err      = err_q;
  assign bus.busy     = busy_q;
  assign bus.wr_ready = wr_ready_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;

`ifdef DMA_MEM_RESPONDER_STATS_EN
  logic [31:0] stat_wr_q, stat_rd_q;
  logic [15:0] stat_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_wr_q  <= '0;
      stat_rd_q  <= '0;
      stat_err_q <= '0;
    end else begin
      if (wr_en_c && (stat_wr_q != '1))           stat_wr_q  <= stat_wr_q + 32'd1;
      if (pop_c && (stat_rd_q != '1))             stat_rd_q  <= stat_rd_q + 32'd1;
      if (ack_q && err_q && (stat_err_q != '1))   stat_err_q <= stat_err_q + 16'd1;
    end
  end

  assign stat_wr_words = stat_wr_q;
  assign stat_rd_words = stat_rd_q;
  assign stat_errs     = stat_err_q;
`endif

endmodule
